// File: rtl/prbs_bert_ctrl_if.sv
// Control/status and receive-stream bundle for the PRBS7 bit-error-rate controller.
// The master side (test sequencer / receive path) drives run control and rx words;
// the slave side (the controller) returns run status and the measurement counters.
interface prbs_bert_ctrl_if #(
   parameter int WIDTH   = 24,
   parameter int ERR_W   = 16,
   parameter int WORDS_W = 32
);
   logic               start;
   logic               stop;
   logic [WORDS_W-1:0] num_words;
   logic               rx_valid;
   logic [WIDTH-1:0]   rx_data;
   logic               busy;
   logic               locked;
   logic               done;
   logic [ERR_W-1:0]   err_cnt;
   logic [WORDS_W-1:0] word_cnt;
   logic               lost_lock;

   modport master (
      output start, stop, num_words, rx_valid, rx_data,
      input  busy, locked, done, err_cnt, word_cnt, lost_lock
   );

   modport slave (
      input  start, stop, num_words, rx_valid, rx_data,
      output busy, locked, done, err_cnt, word_cnt, lost_lock
   );
endinterface

// File: rtl/prbs_bert_ctrl.sv
// PRBS7 (x^7+x^6+1) bit-error-rate test controller.
// Sequences a run (seed -> sync -> locked -> done), self-synchronises an internal
// reference LFSR to the received word stream, then flywheels it while counting
// locked words and bit errors and watching for loss of lock.
module prbs_bert_ctrl #(
   parameter int WIDTH      = 24,
   parameter int TAP1       = 6,
   parameter int TAP2       = 5,
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 4,
   parameter int ERR_W      = 16,
   parameter int WORDS_W    = 32
) (
   input logic             clk,
   input logic             rst_n,
   prbs_bert_ctrl_if.slave bus
);

   localparam int PC_W  = $clog2(WIDTH + 1);
   localparam int GR_W  = $clog2(LOCK_CNT + 1);
   localparam int BR_W  = $clog2(UNLOCK_CNT + 1);
   localparam int SUM_W = ((ERR_W > PC_W) ? ERR_W : PC_W) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEED,
      S_SYNC,
      S_LOCKED,
      S_DONE
   } state_t;

   // Advance the LFSR by one full word (WIDTH single-bit steps).
   function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] d;
      d = x;
      for (int i = 0; i < WIDTH; i++) begin
         d = {d[WIDTH-2:0], d[TAP1] ^ d[TAP2]};
      end
      return d;
   endfunction

   function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [PC_W-1:0] c;
      c = '0;
      for (int i = 0; i < WIDTH; i++) begin
         c = c + PC_W'(v[i]);
      end
      return c;
   endfunction

   // Error accumulation sticks at all-ones instead of wrapping.
   function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc,
                                                input logic [PC_W-1:0]  inc);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(acc) + SUM_W'(inc);
      if (sum[SUM_W-1:ERR_W] != '0) begin
         return '1;
      end
      return sum[ERR_W-1:0];
   endfunction

   state_t             state_q, state_d;
   // ref holds the previous received word while syncing and the
   // flywheeled expected word while locked.
   logic [WIDTH-1:0]   ref_q, ref_d;
   logic [GR_W-1:0]    good_q, good_d;
   logic [BR_W-1:0]    bad_q, bad_d;
   logic [WORDS_W-1:0] target_q, target_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic [WORDS_W-1:0] words_q, words_d;
   logic               lost_q, lost_d;
   logic               busy_q, busy_d;
   logic               locked_q, locked_d;
   logic               done_q, done_d;

   logic [WIDTH-1:0]   adv_ref;
   logic [WIDTH-1:0]   adv_rx;
   logic [PC_W-1:0]    pc;
   logic [WORDS_W-1:0] words_inc;

   assign adv_ref   = adv(ref_q);
   assign adv_rx    = adv(bus.rx_data);
   assign pc        = popcount(bus.rx_data ^ ref_q);
   assign words_inc = words_q + WORDS_W'(1);

   // Run sequencing, sync/lock tracking and counter updates.
   always_comb begin
      state_d  = state_q;
      ref_d    = ref_q;
      good_d   = good_q;
      bad_d    = bad_q;
      target_d = target_q;
      err_d    = err_q;
      words_d  = words_q;
      lost_d   = lost_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d  = S_SEED;
               err_d    = '0;
               words_d  = '0;
               lost_d   = 1'b0;
               target_d = bus.num_words;
            end
         end
         S_SEED: begin
            if (bus.stop) begin
               state_d = S_DONE;
            end else if (bus.rx_valid) begin
               ref_d   = bus.rx_data;
               good_d  = '0;
               state_d = S_SYNC;
            end
         end
         S_SYNC: begin
            if (bus.stop) begin
               state_d = S_DONE;
            end else if (bus.rx_valid) begin
               ref_d = bus.rx_data;
               if (bus.rx_data == adv_ref) begin
                  if (good_q == GR_W'(LOCK_CNT - 1)) begin
                     state_d = S_LOCKED;
                     ref_d   = adv_rx;
                     good_d  = '0;
                     bad_d   = '0;
                  end else begin
                     good_d = good_q + GR_W'(1);
                  end
               end else begin
                  good_d = '0;
               end
            end
         end
         S_LOCKED: begin
            if (bus.rx_valid) begin
               err_d   = sat_add(err_q, pc);
               words_d = words_inc;
               ref_d   = adv_ref;
               bad_d   = (pc != '0) ? (bad_q + BR_W'(1)) : '0;
               // Reaching the requested length wins over a simultaneous unlock.
               if ((target_q != '0) && (words_inc == target_q)) begin
                  state_d = S_DONE;
               end else if ((pc != '0) && (bad_q == BR_W'(UNLOCK_CNT - 1))) begin
                  state_d = S_SYNC;
                  good_d  = '0;
                  bad_d   = '0;
                  ref_d   = bus.rx_data;
                  lost_d  = 1'b1;
               end
            end
            // A word arriving with stop is still counted above.
            if (bus.stop) begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d   = (state_d == S_SEED) || (state_d == S_SYNC) || (state_d == S_LOCKED);
      locked_d = (state_d == S_LOCKED);
      done_d   = (state_d == S_DONE);
   end

   // State, reference word, counters and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         ref_q    <= '0;
         good_q   <= '0;
         bad_q    <= '0;
         target_q <= '0;
         err_q    <= '0;
         words_q  <= '0;
         lost_q   <= 1'b0;
         busy_q   <= 1'b0;
         locked_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ref_q    <= ref_d;
         good_q   <= good_d;
         bad_q    <= bad_d;
         target_q <= target_d;
         err_q    <= err_d;
         words_q  <= words_d;
         lost_q   <= lost_d;
         busy_q   <= busy_d;
         locked_q <= locked_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.locked    = locked_q;
   assign bus.done      = done_q;
   assign bus.err_cnt   = err_q;
   assign bus.word_cnt  = words_q;
   assign bus.lost_lock = lost_q;

endmodule

// File: tb/tb_prbs_bert_ctrl.sv
// Bench for prbs_bert_ctrl: randomized PRBS7 streams with injected errors, checked
// against a word-level reference model of the run/sync/lock rules.
module tb_prbs_bert_ctrl;
   localparam int WIDTH      = 24;
   localparam int WORDS_W    = 32;
   localparam int LOCK_CNT   = 4;
   localparam int UNLOCK_CNT = 4;
   localparam int MAXW       = 200;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   prbs_bert_ctrl_if #(.WIDTH(WIDTH), .ERR_W(16), .WORDS_W(WORDS_W)) bus ();
   prbs_bert_ctrl_if #(.WIDTH(WIDTH), .ERR_W(4),  .WORDS_W(WORDS_W)) sbus ();

   prbs_bert_ctrl #(.WIDTH(WIDTH), .TAP1(6), .TAP2(5), .LOCK_CNT(LOCK_CNT),
                    .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(16), .WORDS_W(WORDS_W))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   prbs_bert_ctrl #(.WIDTH(WIDTH), .TAP1(6), .TAP2(5), .LOCK_CNT(LOCK_CNT),
                    .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(4), .WORDS_W(WORDS_W))
      dut_sat (.clk(clk), .rst_n(rst_n), .bus(sbus));

   typedef struct packed {
      logic        busy;
      logic        locked;
      logic        done;
      logic        lost;
      logic [15:0] err;
      logic [31:0] words;
   } snap_t;

   int n_checks = 0;
   int n_fail   = 0;

   logic [WIDTH-1:0] clean [MAXW];

   // Reference model state
   bit               m_busy, m_locked, m_done, m_lost, m_seeded;
   int               m_good, m_bad, m_err, m_errmax;
   logic [WIDTH-1:0] m_ref;
   logic [31:0]      m_words, m_target;

   // Next generator word: continue the bit sequence s[n] = s[n-7] ^ s[n-6]
   // for WIDTH more bits; word bit 0 is the newest bit.
   function automatic logic [WIDTH-1:0] adv_model(input logic [WIDTH-1:0] x);
      bit b [2*WIDTH];
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) b[WIDTH-1-i] = x[i];
      for (int n = WIDTH; n < 2*WIDTH; n++) b[n] = b[n-7] ^ b[n-6];
      for (int i = 0; i < WIDTH; i++) r[i] = b[2*WIDTH-1-i];
      return r;
   endfunction

   function automatic void build_stream(input logic [WIDTH-1:0] seed);
      clean[0] = seed;
      for (int k = 1; k < MAXW; k++) clean[k] = adv_model(clean[k-1]);
   endfunction

   function automatic logic [WIDTH-1:0] rand_seed();
      logic [WIDTH-1:0] s;
      s = WIDTH'($urandom);
      s[0] = 1'b1;
      return s;
   endfunction

   function automatic void model_reset();
      m_busy = 0; m_locked = 0; m_done = 0; m_lost = 0; m_seeded = 0;
      m_good = 0; m_bad = 0; m_err = 0; m_ref = '0; m_words = '0; m_target = '0;
   endfunction

   function automatic void model_end_run();
      m_busy = 0; m_locked = 0; m_done = 1;
   endfunction

   function automatic void model_step(input logic v, input logic [WIDTH-1:0] d,
                                      input logic st, input logic sp,
                                      input logic [31:0] num);
      int e;
      if (!m_busy) begin
         if (st) begin
            m_busy = 1; m_done = 0; m_locked = 0; m_seeded = 0;
            m_good = 0; m_bad = 0; m_err = 0; m_words = '0; m_lost = 0;
            m_target = num;
         end
         return;
      end
      if (v) begin
         if (m_locked) begin
            e = $countones(d ^ m_ref);
            m_err = (m_err + e > m_errmax) ? m_errmax : m_err + e;
            m_words = m_words + 1;
            m_ref = adv_model(m_ref);
            m_bad = (e != 0) ? m_bad + 1 : 0;
            if (m_target != 0 && m_words == m_target) begin
               model_end_run();
            end else if (m_bad == UNLOCK_CNT) begin
               m_locked = 0; m_good = 0; m_ref = d; m_lost = 1;
            end
         end else if (!m_seeded) begin
            m_seeded = 1; m_ref = d; m_good = 0;
         end else begin
            if (d == adv_model(m_ref)) m_good++;
            else m_good = 0;
            if (m_good == LOCK_CNT) begin
               m_locked = 1; m_bad = 0; m_ref = adv_model(d);
            end else begin
               m_ref = d;
            end
         end
      end
      if (sp && m_busy) model_end_run();
   endfunction

   function automatic snap_t obs_main();
      snap_t s;
      s.busy = bus.busy; s.locked = bus.locked; s.done = bus.done; s.lost = bus.lost_lock;
      s.err = bus.err_cnt; s.words = bus.word_cnt;
      return s;
   endfunction

   function automatic snap_t obs_sat();
      snap_t s;
      s.busy = sbus.busy; s.locked = sbus.locked; s.done = sbus.done; s.lost = sbus.lost_lock;
      s.err = 16'(sbus.err_cnt); s.words = sbus.word_cnt;
      return s;
   endfunction

   function automatic snap_t model_exp();
      snap_t s;
      s.busy = m_busy; s.locked = m_locked; s.done = m_done; s.lost = m_lost;
      s.err = 16'(m_err); s.words = m_words;
      return s;
   endfunction

   // Apply one cycle of inputs to the selected DUT and advance the model.
   task automatic cycle(input bit sel, input logic v, input logic [WIDTH-1:0] d,
                        input logic st, input logic sp);
      logic [31:0] num;
      num = sel ? sbus.num_words : bus.num_words;
      if (sel) begin
         sbus.rx_valid = v; sbus.rx_data = d; sbus.start = st; sbus.stop = sp;
      end else begin
         bus.rx_valid = v; bus.rx_data = d; bus.start = st; bus.stop = sp;
      end
      model_step(v, d, st, sp, num);
      @(posedge clk);
      #1;
      bus.start = 0; bus.stop = 0; bus.rx_valid = 0;
      sbus.start = 0; sbus.stop = 0; sbus.rx_valid = 0;
   endtask

   task automatic test_reset();
      snap_t o;
      bus.start = 0; bus.stop = 0; bus.num_words = '0; bus.rx_valid = 0; bus.rx_data = '0;
      sbus.start = 0; sbus.stop = 0; sbus.num_words = '0; sbus.rx_valid = 0; sbus.rx_data = '0;
      m_errmax = 65535;
      model_reset();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (obs_main() !== '0) begin
         n_fail++; $display("FAIL reset_main: got %h, want 0", obs_main());
      end
      n_checks++;
      if (obs_sat() !== '0) begin
         n_fail++; $display("FAIL reset_sat: got %h, want 0", obs_sat());
      end
      rst_n = 1;
      cycle(0, 1'b1, WIDTH'($urandom), 1'b0, 1'b1);
      o = obs_main();
      n_checks++;
      if (o !== model_exp()) begin
         n_fail++; $display("FAIL reset_idle_hold: got %h, want %h", o, model_exp());
      end
   endtask

   task automatic test_clean_run();
      snap_t o;
      build_stream(24'h000001);
      bus.num_words = 100;
      cycle(0, 1'b0, '0, 1'b1, 1'b0);
      bus.num_words = 7;
      o = obs_main();
      n_checks++;
      if (o.busy !== 1'b1 || o.done !== 1'b0 || o.words !== 0) begin
         n_fail++; $display("FAIL t1_start: got %h, want busy only", o);
      end
      for (int k = 0; k < 105; k++) begin
         cycle(0, 1'b1, clean[k], 1'b0, 1'b0);
         o = obs_main();
         n_checks++;
         if (o !== model_exp()) begin
            n_fail++; $display("FAIL t1_word%0d: got %h, want %h", k, o, model_exp());
         end
         if (k == 3 || k == 4) begin
            n_checks++;
            if (o.locked !== (k == 4)) begin
               n_fail++; $display("FAIL t1_lock_time word%0d: locked=%b, want %0d", k, o.locked, (k == 4));
            end
         end
      end
      for (int k = 0; k < 3; k++) cycle(0, 1'b1, WIDTH'($urandom), 1'b0, 1'b0);
      o = obs_main();
      n_checks++;
      if (o.done !== 1'b1 || o.busy !== 1'b0 || o.words !== 100 || o.err !== 0 || o.lost !== 1'b0) begin
         n_fail++; $display("FAIL t1_result: got %h, want done words=100 err=0 lost=0", o);
      end
   endtask

   task automatic test_injected_errors();
      snap_t o;
      logic [WIDTH-1:0] d;
      build_stream(rand_seed());
      bus.num_words = 100;
      cycle(0, 1'b0, '0, 1'b1, 1'b0);
      o = obs_main();
      n_checks++;
      if (o.err !== 0 || o.words !== 0 || o.done !== 1'b0 || o.busy !== 1'b1) begin
         n_fail++; $display("FAIL t2_restart_clear: got %h, want busy with cleared counters", o);
      end
      for (int k = 0; k < 105; k++) begin
         if ($urandom_range(0, 3) == 0) cycle(0, 1'b0, WIDTH'($urandom), 1'b0, 1'b0);
         d = clean[k];
         if (k == 4 + 10) d = d ^ 24'h000003;
         if (k == 4 + 50) d = d ^ 24'h800000;
         cycle(0, 1'b1, d, 1'b0, 1'b0);
         o = obs_main();
         n_checks++;
         if (o !== model_exp()) begin
            n_fail++; $display("FAIL t2_word%0d: got %h, want %h", k, o, model_exp());
         end
         if (k >= 4 && k < 104) begin
            n_checks++;
            if (o.locked !== 1'b1) begin
               n_fail++; $display("FAIL t2_stay_locked word%0d: locked=%b, want 1", k, o.locked);
            end
         end
      end
      n_checks++;
      if (o.err !== 3 || o.words !== 100 || o.done !== 1'b1 || o.lost !== 1'b0) begin
         n_fail++; $display("FAIL t2_result: got %h, want err=3 words=100 done", o);
      end
   endtask

   task automatic test_loss_of_lock();
      snap_t o;
      build_stream(rand_seed());
      bus.num_words = 0;
      cycle(0, 1'b0, '0, 1'b1, 1'b0);
      for (int k = 0; k < 23; k++) begin
         cycle(0, 1'b1, (k >= 11 && k <= 14) ? (clean[k] ^ 24'h000001) : clean[k], 1'b0, 1'b0);
         o = obs_main();
         n_checks++;
         if (o !== model_exp()) begin
            n_fail++; $display("FAIL t3_word%0d: got %h, want %h", k, o, model_exp());
         end
         if (k == 13) begin
            n_checks++;
            if (o.locked !== 1'b1 || o.lost !== 1'b0) begin
               n_fail++; $display("FAIL t3_three_bad: got %h, want still locked", o);
            end
         end
         if (k == 14) begin
            n_checks++;
            if (o.locked !== 1'b0 || o.lost !== 1'b1 || o.err !== 4 || o.words !== 10 || o.busy !== 1'b1) begin
               n_fail++; $display("FAIL t3_unlock: got %h, want unlocked lost=1 err=4 words=10", o);
            end
         end
         if (k == 18 || k == 19) begin
            n_checks++;
            if (o.locked !== (k == 19) || o.words !== 10) begin
               n_fail++; $display("FAIL t3_relock word%0d: got %h, want locked=%0d words=10", k, o, (k == 19));
            end
         end
      end
      n_checks++;
      if (o.words !== 13 || o.err !== 4 || o.locked !== 1'b1) begin
         n_fail++; $display("FAIL t3_continue: got %h, want words=13 err=4 locked", o);
      end
      cycle(0, 1'b0, '0, 1'b0, 1'b1);
      o = obs_main();
      n_checks++;
      if (o.done !== 1'b1 || o.words !== 13 || o.lost !== 1'b1) begin
         n_fail++; $display("FAIL t3_stop: got %h, want done words=13 lost=1", o);
      end
   endtask

   task automatic test_sync_glitch();
      snap_t o;
      logic [WIDTH-1:0] mask;
      build_stream(rand_seed());
      mask = WIDTH'($urandom);
      if (mask == '0) mask = 24'h000100;
      bus.num_words = 0;
      cycle(0, 1'b0, '0, 1'b1, 1'b0);
      for (int k = 0; k < 9; k++) begin
         cycle(0, 1'b1, (k == 3) ? (clean[k] ^ mask) : clean[k], 1'b0, 1'b0);
         o = obs_main();
         n_checks++;
         if (o !== model_exp()) begin
            n_fail++; $display("FAIL t4_word%0d: got %h, want %h", k, o, model_exp());
         end
         if (k >= 4) begin
            n_checks++;
            if (o.locked !== (k == 8)) begin
               n_fail++; $display("FAIL t4_lock_time word%0d: locked=%b, want %0d", k, o.locked, (k == 8));
            end
         end
      end
      cycle(0, 1'b1, clean[9], 1'b0, 1'b1);
      o = obs_main();
      n_checks++;
      if (o.done !== 1'b1 || o.words !== 1 || o.err !== 0 || o.lost !== 1'b0) begin
         n_fail++; $display("FAIL t4_stop: got %h, want done words=1 err=0", o);
      end
   endtask

   task automatic test_open_run_stop();
      snap_t o;
      int vc;
      bit stopped;
      logic v;
      build_stream(rand_seed());
      bus.num_words = 0;
      cycle(0, 1'b0, '0, 1'b1, 1'b0);
      vc = 0;
      stopped = 0;
      for (int cyc = 0; cyc < 2000 && !stopped; cyc++) begin
         if (vc >= 5 + 37) begin
            cycle(0, 1'b1, clean[vc], 1'b1, 1'b1);
            stopped = 1;
         end else begin
            v = 1'($urandom_range(0, 1));
            cycle(0, v, v ? clean[vc] : WIDTH'($urandom), (cyc == 3 || cyc == 30), 1'b0);
            if (v) vc++;
         end
         o = obs_main();
         n_checks++;
         if (o !== model_exp()) begin
            n_fail++; $display("FAIL t5_cycle%0d: got %h, want %h", cyc, o, model_exp());
         end
      end
      if (!stopped) begin
         n_checks++; n_fail++;
         $display("FAIL t5_timeout: valid words=%0d, wanted %0d", vc, 5 + 37);
      end
      o = obs_main();
      n_checks++;
      if (o.done !== 1'b1 || o.words !== 38 || o.err !== 0 || o.busy !== 1'b0) begin
         n_fail++; $display("FAIL t5_result: got %h, want done words=38 err=0", o);
      end
   endtask

   task automatic test_saturation_reset();
      snap_t o;
      logic [WIDTH-1:0] d;
      model_reset();
      m_errmax = 15;
      build_stream(rand_seed());
      sbus.num_words = 0;
      cycle(1, 1'b0, '0, 1'b1, 1'b0);
      for (int k = 0; k < 10; k++) begin
         d = (k == 5 || k == 6 || k == 7 || k == 9) ? ~clean[k] : clean[k];
         cycle(1, 1'b1, d, 1'b0, 1'b0);
         o = obs_sat();
         n_checks++;
         if (o !== model_exp()) begin
            n_fail++; $display("FAIL t6_word%0d: got %h, want %h", k, o, model_exp());
         end
         if (k >= 5) begin
            n_checks++;
            if (o.err !== 15 || o.locked !== 1'b1) begin
               n_fail++; $display("FAIL t6_saturate word%0d: got %h, want err=15 locked", k, o);
            end
         end
      end
      #2;
      rst_n = 0;
      #1;
      n_checks++;
      if (obs_sat() !== '0) begin
         n_fail++; $display("FAIL t6_async_reset_sat: got %h, want 0", obs_sat());
      end
      n_checks++;
      if (obs_main() !== '0) begin
         n_fail++; $display("FAIL t6_async_reset_main: got %h, want 0", obs_main());
      end
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1;
      cycle(1, 1'b1, clean[10], 1'b0, 1'b0);
      o = obs_sat();
      n_checks++;
      if (o !== model_exp()) begin
         n_fail++; $display("FAIL t6_after_reset: got %h, want %h", o, model_exp());
      end
   endtask

   initial begin
      test_reset();
      test_clean_run();
      test_injected_errors();
      test_loss_of_lock();
      test_sync_glitch();
      test_open_run_stop();
      test_saturation_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/prbs_bert_ctrl.md
Name: prbs_bert_ctrl

Overview:
Bit-error-rate test controller for the PRBS7 datapath: x^7+x^6+1, taps TAP1/TAP2, WIDTH bits advanced per word.
- Sequences a test run: seed, sync, locked measurement, done.
- Self-synchronises an internal expected-sequence LFSR to a received PRBS word stream, then flywheels it.
- Counts words and bit errors; detects loss of lock.
- Sits on the receive side of a loopback, opposite the PRBS generator.

Parameters:
WIDTH, 24, bits per received word; must be >= 7
TAP1, 6, first feedback tap index
TAP2, 5, second feedback tap index
LOCK_CNT, 4, consecutive correct predictions required to declare lock (>=1)
UNLOCK_CNT, 4, consecutive errored words in LOCKED that force loss of lock (>=1)
ERR_W, 16, error counter width
WORDS_W, 32, word counter / run length width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse: begin a run (honoured in IDLE/DONE only)
stop  input  1  pulse: end a run (honoured in SEED/SYNC/LOCKED only)
num_words  input  WORDS_W  locked words to measure; 0 = run until stop; sampled at start
rx_valid  input  1  rx_data qualifier
rx_data  input  WIDTH  received PRBS word
busy  output  1  high in SEED/SYNC/LOCKED
locked  output  1  high in LOCKED
done  output  1  high in DONE
err_cnt  output  ERR_W  bit errors in LOCKED words, saturating at all-ones
word_cnt  output  WORDS_W  words received while LOCKED
lost_lock  output  1  sticky: LOCKED->SYNC occurred this run

Behaviour:
- Advance function adv(x): d=x; repeat WIDTH times d={d[WIDTH-2:0], d[TAP1]^d[TAP2]}; result d. Matches the generator word-to-word: next word = adv(current word).
- Reset, asynchronous and active-low: state=IDLE; all outputs 0; internal regs (prev/expected, runs, target) 0.
- All outputs are registered and update the cycle after the triggering edge.
- IDLE: start -> SEED. Clears err_cnt, word_cnt and lost_lock. Latches num_words.
- SEED: first rx_valid word is stored as prev -> SYNC with good_run=0.
- SYNC, per rx_valid word:
  - rx_data==adv(prev): good_run++. When good_run reaches LOCK_CNT -> LOCKED; expected=adv(rx_data); bad_run=0.
  - Mismatch: good_run=0.
  - prev<=rx_data always (reseed).
  - No error/word counting in SYNC.
- LOCKED, per rx_valid word:
  - err_cnt += popcount(rx_data^expected), saturating.
  - word_cnt++.
  - expected<=adv(expected) (flywheel, never reseeded from rx_data).
  - Nonzero mismatch: bad_run++, else bad_run=0. When bad_run reaches UNLOCK_CNT -> SYNC; good_run=0; prev=rx_data; lost_lock=1. word_cnt and err_cnt are kept.
  - num_words!=0 and word_cnt+1==num_words on this word -> DONE. The last word's errors are counted. The DONE check has priority over the unlock check.
- stop in SEED/SYNC/LOCKED -> DONE. If rx_valid is in the same cycle in LOCKED, that word is counted first.
- DONE: done=1; counters hold. start -> SEED with clears, as from IDLE. stop ignored.
- start while busy: ignored. start+stop in the same cycle: handled per state rules above.
- rx_valid low: no state, counter or LFSR change.
- word_cnt wraps (unbounded run); err_cnt saturates.
- Reset mid-run: immediate return to IDLE; results lost.

Test Plan:
1. Error-free run: start, num_words=100, drive a clean PRBS stream from generator seed 1 with rx_valid every cycle. Expect locked high the cycle after the 5th word (1 seed + LOCK_CNT), then done with word_cnt=100, err_cnt=0, lost_lock=0.
2. Injected errors: as test 1, but XOR 0x000003 into locked word 10 and 0x800000 into locked word 50. Expect err_cnt=3, locked stays high, word_cnt=100.
3. Loss of lock: after lock, corrupt 4 consecutive words (0x000001 each). Expect locked low after the 4th, lost_lock=1, err_cnt=4. Resume the clean stream: relock after LOCK_CNT good predictions, and word_cnt continues from its held value.
4. Sync glitch: a corrupted word during SYNC resets good_run. Expect lock only after 4 subsequent consecutive correct predictions.
5. Open run and stop: num_words=0, rx_valid toggling 50%, stop after 37 locked words with rx_valid high on the stop cycle. Expect done, word_cnt=38. A start pulse while busy has no effect.
6. Saturation and reset: ERR_W=4, feed inverted words in LOCKED. Expect err_cnt to stick at 15. Assert rst_n low mid-run: all outputs 0 immediately.
